// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared types and constants for the write-back datapath
package datapath_pkg;

  typedef enum logic [1:0] {IDLE, LOAD_WAIT, STORE_WAIT} wb_state_t;

  localparam logic [3:0] PC_REG       = 4'd15;
  localparam int         DEFAULT_BITS = 24;

endpackage

// File: rtl/mem_timeout_counter.sv
// rtl/mem_timeout_counter.sv - wait-cycle counter that flags an unanswered memory access
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  // Counter reads 0 in the first wait cycle, so expiry lands on the last permitted cycle.
  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/memory_writeback_stage.sv
// rtl/memory_writeback_stage.sv - final stage: data-memory access and register-file write-back
module memory_writeback_stage
  import datapath_pkg::*;
#(
  parameter int BITS           = DEFAULT_BITS,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic            IN_LOAD,
  input  logic            IN_STORE,
  input  logic            IN_WB,
  input  logic [3:0]      IN_RD,
  input  logic [BITS-1:0] IN_RESULT,
  input  logic [BITS-1:0] IN_STORE_DATA,
  output logic            DMEM_REQ,
  output logic            DMEM_WE,
  output logic [BITS-1:0] DMEM_ADDR,
  output logic [BITS-1:0] DMEM_WDATA,
  input  logic [BITS-1:0] DMEM_RDATA,
  input  logic            DMEM_ACK,
  output logic            WRT_ENA,
  output logic [3:0]      ADDRS_RD,
  output logic [BITS-1:0] WRT_DATA,
  output logic            PC_WRITE,
  output logic            BUSY,
  output logic            ERR
);

  wb_state_t       state, state_d;
  logic            accept, do_load, do_store, do_wb, expired;
  logic [3:0]      rd_q, rd_d, addrs_rd_d;
  logic            req_d, we_d, wrt_ena_d, pc_write_d, err_d;
  logic [BITS-1:0] addr_d, wdata_d, wrt_data_d;

  assign IN_READY = (state == IDLE) && RST;
  assign BUSY     = (state != IDLE);
  assign accept   = IN_VALID && IN_READY;
  assign do_load  = accept && IN_LOAD;
  assign do_store = accept && IN_STORE && !IN_LOAD;
  assign do_wb    = accept && IN_WB && !IN_LOAD && !IN_STORE;

  mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
    .clk     (CLK),
    .resetn  (RST),
    .clear   (do_load || do_store),
    .enable  (state != IDLE),
    .expired (expired)
  );

  always_ff @(posedge CLK) begin
    if (!RST) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: begin
        if (do_load)       state_d = LOAD_WAIT;
        else if (do_store) state_d = STORE_WAIT;
      end
      LOAD_WAIT, STORE_WAIT: begin
        if (DMEM_ACK || expired) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered outputs; ACK is checked before expiry so a late ACK still completes.
  always_comb begin
    req_d      = DMEM_REQ;
    we_d       = DMEM_WE;
    addr_d     = DMEM_ADDR;
    wdata_d    = DMEM_WDATA;
    rd_d       = rd_q;
    wrt_ena_d  = 1'b0;
    addrs_rd_d = ADDRS_RD;
    wrt_data_d = WRT_DATA;
    err_d      = ERR;
    case (state)
      IDLE: begin
        if (do_load) begin
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = IN_RESULT;
          rd_d   = IN_RD;
        end else if (do_store) begin
          req_d   = 1'b1;
          we_d    = 1'b1;
          addr_d  = IN_RESULT;
          wdata_d = IN_STORE_DATA;
        end else if (do_wb) begin
          wrt_ena_d  = 1'b1;
          addrs_rd_d = IN_RD;
          wrt_data_d = IN_RESULT;
        end
      end
      LOAD_WAIT: begin
        if (DMEM_ACK) begin
          req_d      = 1'b0;
          wrt_ena_d  = 1'b1;
          addrs_rd_d = rd_q;
          wrt_data_d = DMEM_RDATA;
        end else if (expired) begin
          req_d = 1'b0;
          err_d = 1'b1;
        end
      end
      STORE_WAIT: begin
        if (DMEM_ACK) begin
          req_d = 1'b0;
        end else if (expired) begin
          req_d = 1'b0;
          err_d = 1'b1;
        end
      end
      default: req_d = 1'b0;
    endcase
    pc_write_d = wrt_ena_d && (addrs_rd_d == PC_REG);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      DMEM_REQ   <= 1'b0;
      DMEM_WE    <= 1'b0;
      DMEM_ADDR  <= '0;
      DMEM_WDATA <= '0;
      rd_q       <= '0;
      WRT_ENA    <= 1'b0;
      ADDRS_RD   <= '0;
      WRT_DATA   <= '0;
      PC_WRITE   <= 1'b0;
      ERR        <= 1'b0;
    end else begin
      DMEM_REQ   <= req_d;
      DMEM_WE    <= we_d;
      DMEM_ADDR  <= addr_d;
      DMEM_WDATA <= wdata_d;
      rd_q       <= rd_d;
      WRT_ENA    <= wrt_ena_d;
      ADDRS_RD   <= addrs_rd_d;
      WRT_DATA   <= wrt_data_d;
      PC_WRITE   <= pc_write_d;
      ERR        <= err_d;
    end
  end

endmodule
